// File: rtl/mesh_output_arbiter_if.sv
// mesh_output_arbiter_if: input-FIFO heads, output link and credit signals of one router output port.
interface mesh_output_arbiter_if #(
    parameter int N  = 4,
    parameter int FW = 16,
    parameter int CW = 4
);
    logic [N-1:0]          fifo_empty;
    logic [N-1:0]          fifo_tail;
    logic [N-1:0][FW-1:0]  fifo_dout;
    logic [N-1:0]          fifo_rd_en;
    logic [FW-1:0]         out_flit;
    logic                  out_valid;
    logic                  credit_in;
    logic [CW-1:0]         credit_cnt;
    logic                  locked;
    logic [$clog2(N)-1:0]  owner;
    logic                  credit_err;
    modport master (
        input  fifo_empty, fifo_tail, fifo_dout, credit_in,
        output fifo_rd_en, out_flit, out_valid, credit_cnt, locked, owner, credit_err
    );
    modport slave (
        output fifo_empty, fifo_tail, fifo_dout, credit_in,
        input  fifo_rd_en, out_flit, out_valid, credit_cnt, locked, owner, credit_err
    );
endinterface

// File: rtl/mesh_output_arbiter.sv
// mesh_output_arbiter: wormhole round-robin output scheduler with credit-based flow control.
module mesh_output_arbiter #(
    parameter int  N       = 4,
    parameter int  CREDITS = 8,
    parameter int  FW      = 16,
    localparam int CW      = $clog2(CREDITS + 1),
    localparam int OW      = $clog2(N)
) (
    input logic                   clk,
    input logic                   reset,
    mesh_output_arbiter_if.master bus
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t         state, state_nx;
    logic [OW-1:0]  rr_ptr, owner, rr_g, sel, idx;
    logic [CW-1:0]  credit_cnt;
    logic [FW-1:0]  out_flit;
    logic [N-1:0]   rd_en;
    logic           out_valid, credit_err, any_req, send;

    // descending scan so the candidate closest to rr_ptr wins
    always_comb begin
        rr_g = rr_ptr;
        any_req = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = OW'((int'(rr_ptr) + i) % N);
            if (!bus.fifo_empty[idx]) begin
                rr_g = idx;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        sel = (state == LOCKED) ? owner : rr_g;
        send = reset && (credit_cnt != '0) && ((state == LOCKED) ? !bus.fifo_empty[owner] : any_req);
        rd_en = send ? (N'(1) << sel) : '0;
        state_nx = send ? (bus.fifo_tail[sel] ? IDLE : LOCKED) : state;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            owner <= '0;
            credit_cnt <= CW'(CREDITS);
            out_valid <= 1'b0;
            out_flit <= '0;
            credit_err <= 1'b0;
        end else begin
            state <= state_nx;
            out_valid <= send;
            if (send) begin
                owner <= sel;
                out_flit <= bus.fifo_dout[sel];
            end
            if (send && bus.fifo_tail[sel])
                rr_ptr <= (sel == OW'(N - 1)) ? '0 : sel + OW'(1);
            if (bus.credit_in && !send) begin
                if (credit_cnt == CW'(CREDITS))
                    credit_err <= 1'b1;
                else
                    credit_cnt <= credit_cnt + CW'(1);
            end else if (send && !bus.credit_in) begin
                credit_cnt <= credit_cnt - CW'(1);
            end
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_flit   = out_flit;
    assign bus.out_valid  = out_valid;
    assign bus.credit_cnt = credit_cnt;
    assign bus.locked     = (state == LOCKED);
    assign bus.owner      = owner;
    assign bus.credit_err = credit_err;
endmodule

// File: tb/tb_mesh_output_arbiter.sv
// tb_mesh_output_arbiter: queue-modelled input FIFOs, packet-level reference model and output scoreboard.
module tb_mesh_output_arbiter;
    localparam int N = 4, CREDITS = 8, FW = 16, CW = $clog2(CREDITS + 1);
    typedef struct {logic [FW-1:0] d; bit t;} fl_t;
    typedef struct {logic [FW-1:0] d; int c;} sb_t;

    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;

    mesh_output_arbiter_if #(.N(N), .FW(FW), .CW(CW)) b();
    mesh_output_arbiter #(.N(N), .CREDITS(CREDITS), .FW(FW)) dut (.clk(clk), .reset(reset), .bus(b));

    fl_t fq[N][$];
    sb_t sb[$];
    sb_t e;
    int n_cmp = 0, n_bad = 0, cyc = 0, seq = 0;
    int m_rr, m_owner, m_cred;
    bit m_lock, m_err;

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_pkt(int i, int len, bit tail_last);
        fl_t f;
        for (int k = 0; k < len; k++) begin
            f.d = FW'((i << 12) | (seq & 'hfff));
            f.t = tail_last && (k == len - 1);
            seq++;
            fq[i].push_back(f);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            b.fifo_empty[i] = (fq[i].size() == 0);
            b.fifo_tail[i]  = (fq[i].size() != 0) ? fq[i][0].t : 1'b0;
            b.fifo_dout[i]  = (fq[i].size() != 0) ? fq[i][0].d : '0;
        end
    endtask

    function automatic bit busy();
        for (int i = 0; i < N; i++) if (fq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // packet-level rules: no credit -> nothing; locked -> owner only; else first non-empty from rr
    function automatic int model_grant();
        if (m_cred == 0) return -1;
        if (m_lock) return (fq[m_owner].size() != 0) ? m_owner : -1;
        for (int k = 0; k < N; k++)
            if (fq[(m_rr + k) % N].size() != 0) return (m_rr + k) % N;
        return -1;
    endfunction

    task automatic step(bit ci);
        int g;
        fl_t f;
        b.credit_in = ci;
        drive();
        @(negedge clk);
        g = model_grant();
        chk("rd_en", int'(b.fifo_rd_en), (g >= 0) ? (1 << g) : 0);
        chk("credit_cnt", int'(b.credit_cnt), m_cred);
        chk("locked", int'(b.locked), int'(m_lock));
        chk("owner", int'(b.owner), m_owner);
        chk("credit_err", int'(b.credit_err), int'(m_err));
        if (g >= 0) sb.push_back('{fq[g][0].d, cyc});
        @(posedge clk);
        cyc++;
        if (g >= 0) begin
            f = fq[g].pop_front();
            m_owner = g;
            m_lock = !f.t;
            if (f.t) m_rr = (g + 1) % N;
        end
        m_cred = m_cred - int'(g >= 0) + int'(ci);
        if (m_cred > CREDITS) begin
            m_cred = CREDITS;
            m_err = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset(int n, bit with_pkt);
        reset = 1'b0;
        b.credit_in = 1'b0;
        for (int i = 0; i < N; i++) fq[i].delete();
        m_rr = 0; m_owner = 0; m_cred = CREDITS; m_lock = 1'b0; m_err = 1'b0;
        if (with_pkt) push_pkt(2, 1, 1'b1);
        drive();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("rd_en_in_reset", int'(b.fifo_rd_en), 0);
            if (k > 0) chk("out_valid_in_reset", int'(b.out_valid), 0);
            @(posedge clk);
            cyc++;
        end
        #1 reset = 1'b1;
    endtask

    task automatic settle();
        for (int k = 0; k < 200 && (busy() || m_cred < CREDITS); k++) step(m_cred < CREDITS);
    endtask

    always @(negedge clk) begin
        if (b.out_valid === 1'b1) begin
            if (sb.size() == 0 || sb[0].c != cyc - 1) begin
                n_cmp++; n_bad++;
                $display("FAIL out_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("out_flit", int'(b.out_flit), int'(e.d));
            end
        end else if (sb.size() != 0 && sb[0].c == cyc - 1) begin
            n_cmp++; n_bad++;
            $display("FAIL out_valid: got 0 expected 1 (cycle %0d)", cyc);
            void'(sb.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b.credit_in = 1'b0;
        drive();
        do_reset(2, 1'b1);
        step(0);
        settle();
        // round robin over single-flit packets, exactly draining all credits
        do_reset(1, 1'b0);
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_pkt(i, 1, 1'b1);
        repeat (9) step(0);
        settle();
        // wormhole lock against a competing FIFO
        push_pkt(1, 3, 1'b1);
        push_pkt(2, 1, 1'b1);
        repeat (5) step(0);
        settle();
        // owner bubble while FIFO3 waits
        push_pkt(0, 1, 1'b0);
        step(0);
        push_pkt(3, 2, 1'b1);
        step(0);
        step(0);
        push_pkt(0, 2, 1'b1);
        repeat (5) step(0);
        settle();
        // credit exhaustion, single return, return during send
        push_pkt(0, 12, 1'b1);
        repeat (10) step(0);
        step(1);
        step(0);
        step(1);
        step(1);
        step(1);
        settle();
        // overflow credit then reset while locked
        step(1);
        step(0);
        push_pkt(1, 4, 1'b1);
        step(0);
        step(0);
        do_reset(1, 1'b0);
        step(0);
        step(0);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int i = int'($urandom_range(0, N - 1));
                if (fq[i].size() < 8) push_pkt(i, int'($urandom_range(1, 4)), 1'b1);
            end
            step((m_cred < CREDITS) && ($urandom_range(0, 1) == 1));
        end
        settle();
        step(0);
        step(0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
